// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first,
// through one full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, next;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bo, accept;
  logic [WIDTH-1:0] nsr;

  assign d      = sa[0] ^ sb[0] ^ br;
  assign bo     = (sb[0] & br) | (~sa[0] & br) | (~sa[0] & sb[0]);
  assign accept = ready & start;
  // sr keeps only the upper WIDTH-1 result bits; the bit that would drop
  // off the bottom on the completing edge is never needed.
  assign nsr    = {d, sr};

  always_comb begin
    next  = state;
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) next = DONE;
      end
      DONE: begin
        done  = 1'b1;
        ready = 1'b1;
        next  = start ? SHIFT : IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b1;
    end else begin
      state <= next;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        br  <= bin;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= nsr[WIDTH-1:1];
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        br  <= bo;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          diff <= nsr;
          bout <= bo;
          zero <= (nsr == '0);
        end
      end
    end
  end

endmodule
